// File: rtl/dual_prio_pkg.sv
// Constants shared by the dual priority encoder and its grant decoder.
package dual_prio_pkg;

    localparam int unsigned NREQ     = 12;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned HOLD_MAX = 15;
    localparam int unsigned CNT_W    = 4;

    localparam logic [IDX_W-1:0] IDX_NONE = 4'hF;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT1 = 2'd1;
    localparam logic [1:0] ST_GRANT2 = 2'd2;

    // A code names a real requester only when it is below NREQ.
    function automatic logic code_ok(input logic [IDX_W-1:0] code);
        return code < IDX_W'(NREQ);
    endfunction

endpackage

// File: rtl/dual_grant_decoder_onehot.sv
// Combinational index-to-one-hot decoder; out-of-range codes decode to all zeros.
module idx_to_onehot
    import dual_prio_pkg::*;
(
    input  logic [IDX_W-1:0] code,
    output logic [NREQ-1:0]  onehot_c
);

    always_comb begin
        onehot_c = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            onehot_c[i] = (code == IDX_W'(i));
        end
    end

endmodule

// File: rtl/dual_grant_decoder.sv
// Turns an accepted (first, second) index pair into sequential one-hot grants,
// each held until done or a hold timeout.
module dual_grant_decoder
    import dual_prio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] first,
    input  logic [IDX_W-1:0] second,
    input  logic             done,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] f_q, f_d;
    logic [IDX_W-1:0] s_q, s_d;
    logic             s_vld_q, s_vld_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] code_sel;
    logic [NREQ-1:0]  onehot_c;
    logic             accept;
    logic             f_ok;
    logic             s_ok;
    logic             hold_rel;

    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign f_ok     = code_ok(first);
    // A duplicate second index would grant the same requester twice.
    assign s_ok     = code_ok(second) && (second != first);
    assign hold_rel = done || (cnt_q == HOLD_LAST);

    idx_to_onehot u_onehot (
        .code     (code_sel),
        .onehot_c (onehot_c)
    );

    // Next state, hold counter, pair capture and the code to be granted next cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        f_d       = f_q;
        s_d       = s_q;
        s_vld_d   = s_vld_q;
        timeout_d = 1'b0;
        code_sel  = IDX_NONE;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f_d     = first;
                    s_d     = second;
                    s_vld_d = s_ok;
                    cnt_d   = '0;
                    if (f_ok) begin
                        state_d  = ST_GRANT1;
                        code_sel = first;
                    end else if (s_ok) begin
                        state_d  = ST_GRANT2;
                        code_sel = second;
                    end
                end
            end
            ST_GRANT1: begin
                code_sel = f_q;
                if (hold_rel) begin
                    cnt_d     = '0;
                    timeout_d = !done;
                    if (s_vld_q) begin
                        state_d  = ST_GRANT2;
                        code_sel = s_q;
                    end else begin
                        state_d  = ST_IDLE;
                        code_sel = IDX_NONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GRANT2: begin
                code_sel = s_q;
                if (hold_rel) begin
                    cnt_d     = '0;
                    timeout_d = !done;
                    state_d   = ST_IDLE;
                    code_sel  = IDX_NONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        gnt_valid_d = busy_d;
        gnt_d       = busy_d ? onehot_c : '0;
        gnt_idx_d   = busy_d ? code_sel : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            f_q         <= '0;
            s_q         <= '0;
            s_vld_q     <= 1'b0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f_q         <= f_d;
            s_q         <= s_d;
            s_vld_q     <= s_vld_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule
